// File: rtl/draw_keeper.sv
// draw_keeper: overlays a KEEPER_W x KEEPER_H sprite fetched from an external
// ROM onto a VGA pixel stream with a fixed 3-cycle latency.
// Optional feature macro: KEEPER_TRANSPARENCY_EN (KEY_COLOR pixels show the
// background instead of the sprite).
module draw_keeper #(
  parameter int          KEEPER_W   = 64,
  parameter int          KEEPER_H   = 96,
  parameter int          ADDR_WIDTH = 20,
  parameter logic [11:0] KEY_COLOR  = 12'hF0F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [10:0]           hcount_in,
  input  logic [10:0]           vcount_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  hblnk_in,
  input  logic                  vblnk_in,
  input  logic [11:0]           rgb_in,
  input  logic [11:0]           xpos,
  input  logic [11:0]           ypos,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [11:0]           rom_data,
  output logic [10:0]           hcount_out,
  output logic [10:0]           vcount_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  hblnk_out,
  output logic                  vblnk_out,
  output logic [11:0]           rgb_out
);

  // One pixel's worth of pass-through data travelling down the pipeline.
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic        in_sprite;
  } pix_t;

  logic [11:0]           x_lat, y_lat;
  logic                  vsync_prev;
  pix_t                  stage1, stage2;
  logic                  in_sprite_next;
  logic [ADDR_WIDTH-1:0] rom_addr_next;
  logic [12:0]           h_ext, v_ext, x_ext, y_ext, dh, dv;
  logic [11:0]           rgb_next;

  // Latch the sprite position once per frame, on the rising edge of vsync,
  // so a position update never tears the frame being drawn.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_lat      <= '0;
      y_lat      <= '0;
      vsync_prev <= 1'b0;
    end else begin
      vsync_prev <= vsync_in;
      if (vsync_in && !vsync_prev) begin
        x_lat <= xpos;
        y_lat <= ypos;
      end
    end
  end

  // Rectangle test and ROM address; 13-bit compares keep x_lat+KEEPER_W from
  // wrapping, so a sprite hanging off the right edge never reappears at column 0.
  always_comb begin
    h_ext          = {2'b00, hcount_in};
    v_ext          = {2'b00, vcount_in};
    x_ext          = {1'b0, x_lat};
    y_ext          = {1'b0, y_lat};
    dh             = h_ext - x_ext;
    dv             = v_ext - y_ext;
    in_sprite_next = (h_ext >= x_ext) && (h_ext < x_ext + 13'(KEEPER_W)) &&
                     (v_ext >= y_ext) && (v_ext < y_ext + 13'(KEEPER_H));
    rom_addr_next  = '0;
    if (in_sprite_next)
      rom_addr_next = ADDR_WIDTH'(dv) * ADDR_WIDTH'(KEEPER_W) + ADDR_WIDTH'(dh);
  end

  // Stage 1 issues the ROM address; stage 2 waits out the ROM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      stage1   <= '0;
      stage2   <= '0;
    end else begin
      rom_addr <= rom_addr_next;
      stage1   <= '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in,
                    rgb: rgb_in, in_sprite: in_sprite_next};
      stage2   <= stage1;
    end
  end

  // Pixel composition: blanking wins, then sprite, then background.
  always_comb begin
    rgb_next = stage2.rgb;
    if (stage2.hblnk || stage2.vblnk) begin
      rgb_next = 12'h000;
    end else if (stage2.in_sprite) begin
`ifdef KEEPER_TRANSPARENCY_EN
      rgb_next = (rom_data == KEY_COLOR) ? stage2.rgb : rom_data;
`else
      rgb_next = rom_data;
`endif
    end
  end

  // Stage 3 registers every output so they stay mutually aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= stage2.hcount;
      vcount_out <= stage2.vcount;
      hsync_out  <= stage2.hsync;
      vsync_out  <= stage2.vsync;
      hblnk_out  <= stage2.hblnk;
      vblnk_out  <= stage2.vblnk;
      rgb_out    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_draw_keeper.sv
// Scoreboard bench for draw_keeper: stimulus pushes expected outputs tagged
// with the cycle they must appear; a negedge monitor pops and compares.
module tb_draw_keeper;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, xpos, ypos;
  logic [19:0] rom_addr;
  logic [11:0] rom_data = 12'h000;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

`ifdef KEEPER_TRANSPARENCY_EN
  localparam logic [11:0] KEY_EXP = 12'h0A0;
`else
  localparam logic [11:0] KEY_EXP = 12'hF0F;
`endif

  draw_keeper dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Sprite ROM model: registered read, pixel value is the low 12 address bits.
  always @(posedge clk) rom_data <= rom_addr[11:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          target;
    int          id;
    logic [11:0] rgb;
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
  } exp_t;

  typedef struct {
    int          target;
    int          id;
    logic [19:0] addr;
  } aexp_t;

  exp_t  sq[$];
  aexp_t aq[$];
  int    n_vec = 0;
  int    n_bad = 0;
  int    vid   = 0;

  // Apply one pixel for one cycle and queue what must come out of it.
  task automatic drive(input logic r, input logic [10:0] h, input logic [10:0] v,
                       input logic hs, input logic vs, input logic hb, input logic vb,
                       input logic [11:0] rgb, input logic [11:0] exp_rgb,
                       input logic achk, input logic [19:0] aexp);
    exp_t  e;
    aexp_t a;
    rst = r; hcount_in = h; vcount_in = v;
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    if (r) begin
      foreach (sq[i]) if (sq[i].target > cyc) begin
        sq[i].rgb = '0; sq[i].h = '0; sq[i].v = '0;
        sq[i].hs = 1'b0; sq[i].vs = 1'b0; sq[i].hb = 1'b0; sq[i].vb = 1'b0;
      end
      foreach (aq[i]) if (aq[i].target > cyc) aq[i].addr = '0;
    end
    e.target = cyc + 3; e.id = vid;
    e.rgb = r ? 12'h000 : exp_rgb;
    e.h   = r ? 11'd0 : h;
    e.v   = r ? 11'd0 : v;
    e.hs  = r ? 1'b0 : hs; e.vs = r ? 1'b0 : vs;
    e.hb  = r ? 1'b0 : hb; e.vb = r ? 1'b0 : vb;
    sq.push_back(e);
    if (r || achk) begin
      a.target = cyc + 1; a.id = vid; a.addr = r ? 20'd0 : aexp;
      aq.push_back(a);
    end
    vid++;
    @(negedge clk);
  endtask

  task automatic pix(input logic [10:0] h, input logic [10:0] v,
                     input logic [11:0] rgb, input logic [11:0] exp_rgb);
    drive(1'b0, h, v, 1'b0, 1'b0, 1'b0, 1'b0, rgb, exp_rgb, 1'b0, 20'd0);
  endtask

  task automatic pixa(input logic [10:0] h, input logic [10:0] v,
                      input logic [11:0] rgb, input logic [11:0] exp_rgb,
                      input logic [19:0] aexp);
    drive(1'b0, h, v, 1'b0, 1'b0, 1'b0, 1'b0, rgb, exp_rgb, 1'b1, aexp);
  endtask

  // Blanked vsync pulse; position (x1,y1) is presented on the rising cycle.
  task automatic vpulse(input logic [11:0] x0, input logic [11:0] y0,
                        input logic [11:0] x1, input logic [11:0] y1);
    xpos = x0; ypos = y0;
    drive(1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h555, 12'h000, 1'b0, 20'd0);
    xpos = x1; ypos = y1;
    drive(1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h555, 12'h000, 1'b0, 20'd0);
  endtask

  // Monitor: compare every queued expectation whose cycle has arrived.
  always @(negedge clk) begin : monitor
    exp_t  e;
    aexp_t a;
    while (sq.size() > 0 && sq[0].target <= cyc) begin
      e = sq.pop_front();
      n_vec++;
      if (rgb_out !== e.rgb || hcount_out !== e.h || vcount_out !== e.v ||
          hsync_out !== e.hs || vsync_out !== e.vs ||
          hblnk_out !== e.hb || vblnk_out !== e.vb) begin
        n_bad++;
        $display("FAIL pixel#%0d: got rgb=%h h=%0d v=%0d hs/vs/hb/vb=%b%b%b%b, want rgb=%h h=%0d v=%0d hs/vs/hb/vb=%b%b%b%b",
                 e.id, rgb_out, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                 e.rgb, e.h, e.v, e.hs, e.vs, e.hb, e.vb);
      end else begin
        $display("pixel#%0d ok: rgb=%h h=%0d v=%0d", e.id, rgb_out, hcount_out, vcount_out);
      end
    end
    while (aq.size() > 0 && aq[0].target <= cyc) begin
      a = aq.pop_front();
      n_vec++;
      if (rom_addr !== a.addr) begin
        n_bad++;
        $display("FAIL rom_addr#%0d: got %0d, want %0d", a.id, rom_addr, a.addr);
      end else begin
        $display("rom_addr#%0d ok: %0d", a.id, rom_addr);
      end
    end
  end

  initial begin
    rst = 1'b1; hcount_in = '0; vcount_in = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = '0; xpos = '0; ypos = '0;
    @(negedge clk);

    // Power-on reset: outputs and address are zero.
    drive(1'b1, 11'd7, 11'd7, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b1, 20'd0);
    drive(1'b1, 11'd7, 11'd7, 1'b1, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b1, 20'd0);
    // After reset the sprite sits at (0,0): (5,3) -> 3*64+5 = 197 = 0x0C5.
    pixa(11'd5, 11'd3, 12'h123, 12'h0C5, 20'd197);

    // Latch (100,50); latency and alignment at (10,10), outside the sprite.
    vpulse(12'd100, 12'd50, 12'd100, 12'd50);
    drive(1'b0, 11'd10, 11'd10, 1'b1, 1'b0, 1'b0, 1'b0, 12'h123, 12'h123, 1'b1, 20'd0);
    drive(1'b0, 11'd10, 11'd11, 1'b0, 1'b0, 1'b1, 1'b0, 12'h123, 12'h000, 1'b0, 20'd0);
    drive(1'b0, 11'd11, 11'd11, 1'b1, 1'b0, 1'b0, 1'b1, 12'h123, 12'h000, 1'b0, 20'd0);

    // Address generation and rectangle boundaries for sprite at (100,50).
    pixa(11'd105, 11'd52, 12'h321, 12'h085, 20'd133);
    pix (11'd99,  11'd52, 12'h321, 12'h321);
    pixa(11'd163, 11'd145, 12'h321, 12'h7FF, 20'd6143);
    pix (11'd164, 11'd52, 12'h321, 12'h321);
    pix (11'd105, 11'd146, 12'h321, 12'h321);

    // Mid-frame position change has no effect until the next vsync rise.
    xpos = 12'd300;
    pixa(11'd105, 11'd53, 12'h456, 12'h0C5, 20'd197);
    pix (11'd305, 11'd53, 12'h456, 12'h456);
    vpulse(12'd300, 12'd50, 12'd300, 12'd50);
    pixa(11'd305, 11'd53, 12'h456, 12'h0C5, 20'd197);
    pix (11'd105, 11'd53, 12'h456, 12'h456);
    // Change on the very cycle of the vsync rise is captured.
    vpulse(12'd300, 12'd50, 12'd500, 12'd50);
    pixa(11'd505, 11'd50, 12'h456, 12'h005, 20'd5);
    pix (11'd305, 11'd53, 12'h456, 12'h456);

    // Right-edge clipping at x=1000: no wrap onto column 0.
    vpulse(12'd1000, 12'd50, 12'd1000, 12'd50);
    pixa(11'd1023, 11'd51, 12'h789, 12'h057, 20'd87);
    pixa(11'd1000, 11'd51, 12'h789, 12'h040, 20'd64);
    pixa(11'd0,    11'd51, 12'h789, 12'h789, 20'd0);
    pix (11'd999,  11'd51, 12'h789, 12'h789);

    // Key colour: row 60, col 15 -> address 3855 -> ROM pixel 0xF0F.
    pixa(11'd1015, 11'd110, 12'h0A0, KEY_EXP, 20'd3855);
    pixa(11'd1016, 11'd110, 12'h0A0, 12'hF10, 20'd3856);
    drive(1'b0, 11'd1015, 11'd110, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0A0, 12'h000, 1'b0, 20'd0);

    // Mid-line reset for two cycles: zeros out, sprite back at (0,0).
    drive(1'b1, 11'd500, 11'd60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h246, 12'h000, 1'b1, 20'd0);
    drive(1'b1, 11'd501, 11'd60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h246, 12'h000, 1'b1, 20'd0);
    pixa(11'd5,   11'd3,  12'h246, 12'h0C5, 20'd197);
    pix (11'd105, 11'd52, 12'h246, 12'h246);
    vpulse(12'd100, 12'd50, 12'd100, 12'd50);
    pixa(11'd105, 11'd52, 12'h246, 12'h085, 20'd133);

    // Drain the pipeline, bounded.
    repeat (8) @(negedge clk);
    if (sq.size() != 0 || aq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sq.size() + aq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/draw_keeper.md
DRAW_KEEPER -- requirements
Module: draw_keeper

Interface
REQ-001 The module SHALL have the following parameters, one per line as name, default, meaning:
- KEEPER_W, 64, sprite width in pixels.
- KEEPER_H, 96, sprite height in pixels.
- ADDR_WIDTH, 20, sprite ROM address width.
- KEY_COLOR, 12'hF0F, transparent colour.
REQ-002 The module SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  input  1  posedge clock, the single clock domain.
- rst  input  1  synchronous active-high reset.
- hcount_in  input  11  pixel column.
- vcount_in  input  11  pixel row.
- hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  VGA timing.
- rgb_in  input  12  background pixel.
- xpos, ypos  input  12  keeper top-left corner, asynchronous to the frame.
- rom_addr  output  ADDR_WIDTH  sprite ROM address.
- rom_data  input  12  ROM pixel, valid 1 cycle after rom_addr.
- hcount_out, vcount_out  output  11  delayed counters.
- hsync_out, vsync_out, hblnk_out, vblnk_out  output  1 each  delayed timing.
- rgb_out  output  12  composed pixel.

Function
REQ-003 Latency SHALL be exactly 3 clk cycles from any input pixel to its output pixel, with all timing and count outputs delayed by the same 3 stages.
REQ-004 Stage 1 SHALL register rom_addr and the stage-1 copies of the counts, timing, rgb_in and the in_sprite flag.
REQ-005 Stage 2 SHALL be a pure delay covering the ROM's 1-cycle read.
REQ-006 Stage 3 SHALL register the outputs.
REQ-007 The module SHALL hold frame-latched copies x_lat and y_lat, updated from xpos and ypos only on the cycle vsync_in rises (vsync_in=1 while its previous value was 0), and held otherwise.
REQ-008 in_sprite SHALL be computed with 13-bit unsigned arithmetic (no wrap) as hcount_in >= x_lat, hcount_in < x_lat+KEEPER_W, vcount_in >= y_lat and vcount_in < y_lat+KEEPER_H.
REQ-009 When in_sprite=1, rom_addr SHALL equal (vcount_in-y_lat)*KEEPER_W + (hcount_in-x_lat), truncated to ADDR_WIDTH; otherwise rom_addr SHALL be 0.
REQ-010 rgb_out SHALL be selected as follows:
- 12'h000 if the delayed hblnk or vblnk is 1;
- else rom_data if the delayed in_sprite is 1 (subject to REQ-015);
- else the delayed rgb_in.
REQ-011 If the sprite lies partly off-screen, only the on-screen pixels SHALL be drawn, and the ROM row/column SHALL still be indexed from the true x_lat and y_lat.
REQ-012 If a position change arrives mid-frame, it SHALL NOT affect the current frame, and SHALL take effect from the next vsync_in rising edge.
REQ-013 If xpos/ypos change on the same cycle as the vsync_in rising edge, the new values SHALL be captured.

Reset
REQ-014 While rst=1 at a clk edge, all pipeline registers, rom_addr, every output and x_lat/y_lat SHALL be cleared to 0.
- The first three post-reset output cycles therefore SHALL carry zeros.
- If rst is asserted mid-frame, the module SHALL draw the sprite at (0,0) until the next vsync_in rising edge latches a position.

Configuration
REQ-015 Macro KEEPER_TRANSPARENCY_EN SHALL control transparency:
- Defined: an in-sprite rom_data equal to KEY_COLOR SHALL be replaced by the delayed rgb_in.
- Undefined: rom_data SHALL always be drawn inside the sprite rectangle, including KEY_COLOR pixels.

Verification
REQ-016 The bench SHALL model the ROM with a 1-cycle registered read, with content addr[11:0] as the pixel value, and SHALL cover the following scenarios:
- Latency: rgb_in=12'h123, with the sprite away from pixel (10,10) -> at (10,10), rgb_out=12'h123 and hcount_out=10 exactly 3 cycles later; hsync, vsync and blank outputs are aligned with it.
- Address: x_lat=100, y_lat=50, pixel (105,52) -> rom_addr=2*64+5=133 one cycle later; rgb_out=12'h085 two cycles after that.
- Frame latch: xpos changes 100->300 mid-frame -> the remaining rows still draw at x=100; after the vsync_in rising edge the sprite is drawn at x=300; a same-cycle change at the vsync_in edge is captured.
- Edge clipping: xpos=1000 on an 1024-wide screen -> columns 1000..1023 are drawn; rom_addr at hcount=1023 is row*64+23; there is no wrap onto column 0.
- Transparency: rom_data=12'hF0F inside the sprite with rgb_in=12'h0A0 -> with the macro defined rgb_out=12'h0A0; without it rgb_out=12'hF0F. Blank pixels give 12'h000 in both builds.
- Reset: rst is asserted for 2 cycles mid-line -> all outputs are 0 on the following edge; x_lat=y_lat=0 until the next vsync_in rise, so the sprite is drawn at (0,0) in between.
